// File: rtl/latency_mem_responder.sv
// Word-addressed memory responder with a fixed response latency and a minimum request interval.
// Define MEM_STALL_INJECT_EN to add LFSR-driven pseudo-random o_ready stalls.
`timescale 1ns/1ps
module latency_mem_responder #(
  parameter int          SIZE       = 1024,
  parameter int          LATENCY    = 4,
  parameter int          INTERVAL   = 2,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_wdata,
  output logic        o_valid,
  output logic [31:0] o_rdata
);

  localparam int AW = $clog2(SIZE);

  generate
    if (LATENCY < 1 || LATENCY > 16 || INTERVAL < 1 || INTERVAL > 16 ||
        SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_params
      $error("latency_mem_responder: illegal SIZE/LATENCY/INTERVAL");
    end
  endgenerate

  logic [31:0]   mem [0:SIZE-1];
  logic [AW-1:0] idx;
  logic          accept;
  logic          stall;
  logic [4:0]    interval_cnt;
  logic          pipe_v [LATENCY];
  logic [31:0]   pipe_d [LATENCY];

  // The address aliases modulo SIZE, so upper and byte-offset bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0]};

  assign idx     = i_addr[AW+1:2];
  assign o_ready = i_rst_n & (interval_cnt == 5'd0) & ~stall;
  assign accept  = o_ready & (i_ren | i_wen);

`ifdef MEM_STALL_INJECT_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-runs regardless of traffic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr <= STALL_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall       = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      interval_cnt <= 5'd0;
    end else if (accept) begin
      interval_cnt <= 5'(INTERVAL - 1);
    end else if (interval_cnt != 5'd0) begin
      interval_cnt <= interval_cnt - 5'd1;
    end
  end

  // Stage 0 captures the pre-write word at the accept edge; data is zero whenever valid is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_d[k] <= 32'h0;
      end
    end else begin
      pipe_v[0] <= accept;
      pipe_d[0] <= (accept && i_ren) ? mem[idx] : 32'h0;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

  // Storage is deliberately not reset so preloaded contents survive a reset.
  always_ff @(posedge i_clk) begin
    if (accept && i_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (i_mask[b]) begin
          mem[idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_valid = pipe_v[LATENCY-1];
  assign o_rdata = pipe_d[LATENCY-1];

endmodule

// File: tb/tb_latency_mem_responder.sv
// Self-checking bench for latency_mem_responder: directed vector table, hand sequences and a
// randomized phase checked cycle-by-cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_latency_mem_responder;

  localparam int SIZE     = 1024;
  localparam int LATENCY  = 4;
  localparam int INTERVAL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready;
  logic [31:0] addr = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] wdata = '0;
  logic        valid;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    int          at;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  resp_t       exp_q[$];
  resp_t       resp_log[$];
  logic [31:0] model_mem [0:SIZE-1];
  int          last_acc = -1000;

  latency_mem_responder #(
    .SIZE(SIZE), .LATENCY(LATENCY), .INTERVAL(INTERVAL), .STALL_SEED(16'hACE1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(ready), .i_addr(addr), .i_ren(ren),
    .i_wen(wen), .i_mask(mask), .i_wdata(wdata), .o_valid(valid), .o_rdata(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  // Reference model: a request seen at this negedge is accepted at the next posedge when at least
  // INTERVAL-1 edges have passed since the previous accept; its response is visible LATENCY-1
  // edges after the accept edge (sampled by the requester on the LATENCY-th edge).
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_acc = -1000;
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_rdata", rdata, 32'h0);
    end else begin
      automatic logic exp_ready = (edge_cnt - last_acc) >= (INTERVAL - 1);
      check("ready", 32'(ready), 32'(exp_ready));
      if (exp_q.size() > 0 && exp_q[0].at == edge_cnt) begin
        check("sb_valid", 32'(valid), 32'd1);
        check("sb_rdata", rdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        check("sb_idle_valid", 32'(valid), 32'd0);
        check("sb_idle_rdata", rdata, 32'h0);
      end
      if (valid) resp_log.push_back('{edge_cnt, rdata});
      if (exp_ready && (ren || wen)) begin
        automatic int i = int'((addr >> 2) % SIZE);
        exp_q.push_back('{edge_cnt + LATENCY, ren ? model_mem[i] : 32'h0});
        if (wen)
          for (int b = 0; b < 4; b++)
            if (mask[b]) model_mem[i][8*b +: 8] = wdata[8*b +: 8];
        last_acc = edge_cnt + 1;
      end
    end
  end

  // Called and returns at 1ns after a posedge; acc is the edge at which the request was taken.
  task automatic applyStimulus(input logic [31:0] a, input logic r, input logic w,
                               input logic [3:0] m, input logic [31:0] d, output int acc);
    int n = 0;
    acc = -1;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      check("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    addr = a; ren = r; wen = w; mask = m; wdata = d;
    @(posedge clk); #1;
    acc = edge_cnt;
    ren = 1'b0; wen = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int exp_at, input logic [31:0] exp_data);
    resp_t r;
    int n = 0;
    while (resp_log.size() == 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (resp_log.size() == 0) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = resp_log.pop_front();
      check({name, "_at"}, 32'(r.at), 32'(exp_at));
      check({name, "_data"}, r.data, exp_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[11];
    int acc, a0, a1, a2;
    int n_rand;

    vecs[0]  = '{32'h10,   1'b0, 1'b1, 4'b1111, 32'hAABBCCDD, 32'h0};
    vecs[1]  = '{32'h10,   1'b0, 1'b1, 4'b0101, 32'h11223344, 32'h0};
    vecs[2]  = '{32'h10,   1'b1, 1'b0, 4'b0000, 32'h0,        32'hAA22CC44};
    vecs[3]  = '{32'h20,   1'b0, 1'b1, 4'b1111, 32'h01020304, 32'h0};
    vecs[4]  = '{32'h20,   1'b1, 1'b1, 4'b1111, 32'hFFFFFFFF, 32'h01020304};
    vecs[5]  = '{32'h20,   1'b1, 1'b0, 4'b1111, 32'h0,        32'hFFFFFFFF};
    vecs[6]  = '{32'h1000, 1'b0, 1'b1, 4'b1111, 32'h5A5A5A5A, 32'h0};
    vecs[7]  = '{32'h0,    1'b1, 1'b0, 4'b0000, 32'h0,        32'h5A5A5A5A};
    vecs[8]  = '{32'h3,    1'b1, 1'b0, 4'b1111, 32'h0,        32'h5A5A5A5A};
    vecs[9]  = '{32'h0,    1'b0, 1'b1, 4'b0000, 32'h12345678, 32'h0};
    vecs[10] = '{32'h0,    1'b1, 1'b0, 4'b0000, 32'h0,        32'h5A5A5A5A};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(ready), 32'd1);

    // Give every word the random phase can touch a known value.
    for (int i = 0; i < 32; i++) applyStimulus(32'(i * 4), 1'b0, 1'b1, 4'hF, 32'h1000_0000 + 32'(i), acc);
    repeat (LATENCY + 2) begin @(posedge clk); #1; end
    resp_log.delete();

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].ren, vecs[v].wen, vecs[v].mask, vecs[v].wdata, acc);
      checkOutput($sformatf("vec%0d", v), acc + LATENCY - 1, vecs[v].exp);
    end

    // Write then read two cycles later: exactly two responses.
    applyStimulus(32'h10, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, a0);
    applyStimulus(32'h10, 1'b1, 1'b0, 4'b0000, 32'h0, a1);
    check("wr_rd_gap", 32'(a1 - a0), 32'd2);
    checkOutput("wr_resp", a0 + LATENCY - 1, 32'h0);
    checkOutput("rd_resp", a1 + LATENCY - 1, 32'hDEADBEEF);
    repeat (8) begin @(posedge clk); #1; end
    check("wr_rd_extra", 32'(resp_log.size()), 32'd0);

    // Back-to-back reads accepted every INTERVAL cycles, returned in order.
    applyStimulus(32'h0, 1'b1, 1'b0, 4'h0, 32'h0, a0);
    applyStimulus(32'h4, 1'b1, 1'b0, 4'h0, 32'h0, a1);
    applyStimulus(32'h8, 1'b1, 1'b0, 4'h0, 32'h0, a2);
    check("b2b_gap01", 32'(a1 - a0), 32'd2);
    check("b2b_gap12", 32'(a2 - a1), 32'd2);
    checkOutput("b2b_r0", a0 + LATENCY - 1, 32'h5A5A5A5A);
    checkOutput("b2b_r1", a1 + LATENCY - 1, 32'h1000_0001);
    checkOutput("b2b_r2", a2 + LATENCY - 1, 32'h1000_0002);

    // Reset while a read is in flight: its response must never appear.
    resp_log.delete();
    applyStimulus(32'h4, 1'b1, 1'b0, 4'h0, 32'h0, a0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check("mid_rst_ready", 32'(ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("mid_rst_ready_after", 32'(ready), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    check("mid_rst_no_resp", 32'(resp_log.size()), 32'd0);

    // Randomized traffic with aliased addresses; the model checks every cycle.
    resp_log.delete();
    n_rand = 0;
    for (int t = 0; t < 150; t++) begin
      int op, gap;
      logic [31:0] ra;
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
      op = int'($urandom_range(0, 2));
      ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(ra, op != 1, op != 0, 4'($urandom_range(0, 15)), $urandom, acc);
      if (acc >= 0) n_rand++;
    end
    repeat (LATENCY + 4) begin @(posedge clk); #1; end
    check("rand_resp_count", 32'(resp_log.size()), 32'(n_rand));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latency_mem_responder.md
Name: latency_mem_responder

Overview:
- Synthesizable word-addressed memory that answers the hart's imem/dmem request interface as the responder end (ready/ren/wen/mask/wdata in, valid/rdata out).
- Models a fixed access latency and a minimum request interval.
- Multiple requests may be in flight, so the hart's fetch/LSU handshakes can be exercised in RTL and on FPGA without a behavioural memory.

Parameters:
- SIZE, 1024, memory depth in 32-bit words; must be a power of two.
- LATENCY, 4, cycles from request accept to o_valid; legal range 1..16.
- INTERVAL, 2, minimum cycles between accepted requests; legal range 1..16.
- STALL_SEED, 16'hACE1, LFSR seed; used only with MEM_STALL_INJECT_EN.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- o_ready  out  1  responder can accept a request this cycle.
- i_addr  in  32  byte address; bits [1:0] ignored.
- i_ren  in  1  read request.
- i_wen  in  1  write request.
- i_mask  in  4  byte-enable for writes; bit n enables byte n.
- i_wdata  in  32  write data.
- o_valid  out  1  one-cycle response strobe.
- o_rdata  out  32  response data, valid only when o_valid=1.

Behaviour:
- Accept: request accepted on a rising edge where o_ready=1 and (i_ren|i_wen)=1. Requests while o_ready=0 are ignored, with no queuing.
- Addressing: word index = i_addr[31:2] modulo SIZE. The address wraps; no error.
- Write: on accept with i_wen=1, each byte lane with i_mask[n]=1 is written at that edge. i_mask is ignored for reads.
- Read data: the word is sampled at the accept edge.
  - With ren&wen both set, the pre-write word is returned.
- Response pipeline: LATENCY-stage shift register of {valid, data}.
  - Every accepted request, read or write, yields exactly one o_valid pulse on the rising edge LATENCY cycles after accept.
  - o_rdata carries the read word, or 32'h0 for write-only requests.
  - o_rdata=0 whenever o_valid=0.
  - Responses return in accept order. Max outstanding = ceil(LATENCY/INTERVAL); no overflow is possible.
- Interval counter:
  - On accept, loads INTERVAL-1; o_ready=0 while the counter is nonzero; decrements each cycle.
  - INTERVAL=1 gives back-to-back accepts with o_ready held at 1.
- Reset (i_rst_n=0, asynchronous):
  - o_ready=0, o_valid=0, o_rdata=0.
  - Pipeline valids cleared, interval counter cleared. Memory contents not reset.
  - Reset mid-operation discards all outstanding responses; they are never emitted.
  - o_ready=1 in the first cycle after i_rst_n deasserts.
- Elaboration: a $error or generate-time failure if LATENCY<1, INTERVAL<1, or SIZE is not a power of two.
- Contents are loadable by hierarchical $readmemh on array mem[0:SIZE-1].

Optional Feature:
- Macro: MEM_STALL_INJECT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to STALL_SEED, advances every cycle.
  - o_ready is additionally forced 0 when lfsr[1:0]==2'b00, to stress handshake tolerance.
  - The interval counter still runs; latency is unchanged.
- Undefined: no LFSR logic; o_ready depends only on the interval counter and reset.

Test Plan:
- Reset, write 32'hDEADBEEF to 0x10 mask 1111 at cycle T, read 0x10 at T+2.
  - -> o_valid at T+4 with rdata 0, and at T+6 with rdata 32'hDEADBEEF; no other valid pulses.
- Preload word 4 = 32'hAABBCCDD, write 32'h11223344 mask 0101 to 0x10, then read 0x10.
  - -> rdata 32'hAA22CC44.
- i_ren held high with addresses 0x0,0x4,0x8 presented whenever o_ready=1 (INTERVAL=2).
  - -> o_ready toggles 1,0,1,0; accepts every 2nd cycle.
  - -> three o_valid pulses spaced 2 cycles apart, each 4 cycles after its accept, in order.
- Write 32'h5A5A5A5A to 0x1000 (SIZE=1024), then read 0x0.
  - -> 32'h5A5A5A5A (wrap alias).
- Accept read at T, drive i_rst_n=0 at T+2 for 2 cycles.
  - -> o_valid never asserts for that read; o_ready=0 during reset and 1 in the first cycle after release.
- Word 8 = 32'h01020304; issue ren=wen=1 at 0x20 with wdata 32'hFFFFFFFF mask 1111.
  - -> response rdata 32'h01020304; a subsequent read of 0x20 returns 32'hFFFFFFFF.
